// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

   // Fetch/issue control states
   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } ifetch_state_e;

   localparam int unsigned ADDR_W               = 32;
   localparam int unsigned INSTR_W              = 32;
   localparam logic [ADDR_W-1:0]  RESET_PC      = 32'h0000_0000;
   localparam logic [ADDR_W-1:0]  PC_INCR       = 32'h0000_0004;
   localparam int unsigned FETCH_TIMEOUT_CYCLES = 16;
   localparam int unsigned TMO_CNT_W            = 5;
   // Opcode 100000 in [31:26], register and function fields zero
   localparam logic [INSTR_W-1:0] NOP_INSTR     = {6'b100000, 26'd0};
   localparam logic [ADDR_W-1:0]  ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage : ifetch_pkg

// File: rtl/pc_next.sv
// Combinational next-PC candidates: sequential (PC+4) and branch
// (PC+4+offset), both wrapping modulo 2^32 and forced word-aligned.
module pc_next
   import ifetch_pkg::*;
(
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [ADDR_W-1:0] immed_i,
   output logic [ADDR_W-1:0] pc_seq_o,
   output logic [ADDR_W-1:0] pc_br_o
);

   logic [ADDR_W-1:0] pc_plus4;

   // Plain 32-bit adds drop the carry, giving the required wrap-around
   always_comb begin
      pc_plus4 = pc_i + PC_INCR;
      pc_seq_o = pc_plus4 & ALIGN_MASK;
      pc_br_o  = (pc_plus4 + immed_i) & ALIGN_MASK;
   end

endmodule : pc_next

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: two-state FETCH/ISSUE controller that requests
// one instruction word at PC, holds it until the decoder retires it, then
// advances PC. Optional fetch watchdog enabled by macro FETCH_TIMEOUT_EN.
module instr_fetch_unit
   import ifetch_pkg::*;
(
   input  logic               Clk_i,
   input  logic               Rst_n_i,
   input  logic               PC_Sel_i,
   input  logic               PC_LdEn_i,
   input  logic [ADDR_W-1:0]  PC_Immed_i,
   output logic               Imem_Req_o,
   output logic [ADDR_W-1:0]  Imem_Addr_o,
   input  logic               Imem_Ack_i,
   input  logic [INSTR_W-1:0] Imem_Rdata_i,
   output logic [INSTR_W-1:0] Instr_o,
   output logic               Instr_Valid_o,
   output logic [ADDR_W-1:0]  PC_o,
   output logic               Fetch_Err_o
);

   ifetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               req_q, req_d;
   logic [ADDR_W-1:0]  pc_seq, pc_br;

`ifdef FETCH_TIMEOUT_EN
   logic [TMO_CNT_W-1:0] tmo_q, tmo_d;
   logic                 err_q, err_d;
   logic                 tmo_expired;

   // This is the 16th consecutive requested FETCH cycle without an Ack
   assign tmo_expired = (tmo_q == TMO_CNT_W'(FETCH_TIMEOUT_CYCLES - 1));
`endif

   pc_next u_pc_next (
      .pc_i     (pc_q),
      .immed_i  (PC_Immed_i),
      .pc_seq_o (pc_seq),
      .pc_br_o  (pc_br)
   );

   // Next-state logic; req_q is low only in the first cycle after reset,
   // so an Ack seen before the request goes out is not mistaken for data
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      req_d   = req_q;
`ifdef FETCH_TIMEOUT_EN
      tmo_d   = tmo_q;
      err_d   = err_q;
`endif
      case (state_q)
         FETCH: begin
            if (!req_q) begin
               req_d = 1'b1;
            end else if (Imem_Ack_i) begin
               instr_d = Imem_Rdata_i;
               req_d   = 1'b0;
               state_d = ISSUE;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (tmo_expired) begin
               instr_d = NOP_INSTR;
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = ISSUE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         ISSUE: begin
            // PC_Sel and PC_Immed matter only on the retiring cycle
            if (PC_LdEn_i) begin
               pc_d    = PC_Sel_i ? pc_br : pc_seq;
               req_d   = 1'b1;
               state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
               tmo_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // State registers; reset abandons any outstanding request
   always_ff @(posedge Clk_i or negedge Rst_n_i) begin
      if (!Rst_n_i) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         req_q   <= req_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   // Watchdog counter and error flag
   always_ff @(posedge Clk_i or negedge Rst_n_i) begin
      if (!Rst_n_i) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign Fetch_Err_o = err_q;
`else
   assign Fetch_Err_o = 1'b0;
`endif

   assign Imem_Req_o    = req_q;
   assign Imem_Addr_o   = pc_q;
   assign PC_o          = pc_q;
   assign Instr_o       = instr_q;
   assign Instr_Valid_o = (state_q == ISSUE);

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; timeout expectations follow FETCH_TIMEOUT_EN.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        pc_sel;
   logic        pc_lden;
   logic [31:0] pc_immed;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic        fetch_err;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [31:0] NOP = 32'h8000_0000;

   instr_fetch_unit dut (
      .Clk_i         (clk),
      .Rst_n_i       (rst_n),
      .PC_Sel_i      (pc_sel),
      .PC_LdEn_i     (pc_lden),
      .PC_Immed_i    (pc_immed),
      .Imem_Req_o    (imem_req),
      .Imem_Addr_o   (imem_addr),
      .Imem_Ack_i    (imem_ack),
      .Imem_Rdata_i  (imem_rdata),
      .Instr_o       (instr),
      .Instr_Valid_o (instr_valid),
      .PC_o          (pc),
      .Fetch_Err_o   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] word);
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack   = 1'b0;
   endtask

   task automatic retire(input logic sel, input logic [31:0] imm);
      pc_lden  = 1'b1;
      pc_sel   = sel;
      pc_immed = imm;
      tick();
      pc_lden  = 1'b0;
      pc_sel   = 1'b0;
      pc_immed = 32'hDEAD_BEEF;
   endtask

   initial begin
      rst_n      = 1'b0;
      pc_sel     = 1'b0;
      pc_lden    = 1'b0;
      pc_immed   = 32'h0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h8000_0001;
      #1;
      check("rst_pc",    pc,                 32'h0);
      check("rst_instr", instr,              32'h0);
      check("rst_valid", {31'd0, instr_valid}, 32'h0);
      check("rst_req",   {31'd0, imem_req},  32'h0);
      check("rst_err",   {31'd0, fetch_err}, 32'h0);

      // Release with Ack tied high
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("c1_req",   {31'd0, imem_req},    32'h1);
      check("c1_addr",  imem_addr,            32'h0);
      check("c1_valid", {31'd0, instr_valid}, 32'h0);
      tick();
      check("c2_valid", {31'd0, instr_valid}, 32'h1);
      check("c2_instr", instr,                32'h8000_0001);
      check("c2_req",   {31'd0, imem_req},    32'h0);

      // Stall 5 cycles in ISSUE with a stray Ack
      imem_rdata = 32'h1111_2222;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_instr", instr,                32'h8000_0001);
         check("stall_pc",    pc,                   32'h0);
         check("stall_req",   {31'd0, imem_req},    32'h0);
         check("stall_valid", {31'd0, instr_valid}, 32'h1);
      end
      imem_ack = 1'b0;
      retire(1'b0, 32'h0);
      check("adv_addr", imem_addr,         32'h4);
      check("adv_req",  {31'd0, imem_req}, 32'h1);

      // PC_LdEn/PC_Sel ignored while fetching
      pc_lden  = 1'b1;
      pc_sel   = 1'b1;
      pc_immed = 32'h100;
      tick();
      tick();
      check("fig_pc",    pc,                   32'h4);
      check("fig_valid", {31'd0, instr_valid}, 32'h0);
      check("fig_req",   {31'd0, imem_req},    32'h1);
      pc_lden = 1'b0;
      pc_sel  = 1'b0;

      fetch(32'h0000_1234);
      check("f2_instr", instr, 32'h0000_1234);
      retire(1'b1, 32'h8);
      check("br_fwd", imem_addr, 32'h10);
      fetch(32'hA);
      retire(1'b1, 32'hFFFF_FFF0);
      check("br_back", imem_addr, 32'h4);
      fetch(32'hB);
      retire(1'b1, 32'h8);
      check("br_fwd2", imem_addr, 32'h10);
      fetch(32'hC);
      retire(1'b0, 32'hFFFF_FFF0);
      check("seq_0x14", imem_addr, 32'h14);
      fetch(32'hD);
      retire(1'b1, 32'h3);
      check("align", imem_addr, 32'h18);
      fetch(32'hE);
      retire(1'b1, 32'hFFFF_FFE0);
      check("to_top", imem_addr, 32'hFFFF_FFFC);
      fetch(32'hF);
      retire(1'b0, 32'h0);
      check("wrap", imem_addr, 32'h0);
      fetch(32'h10);
      retire(1'b1, 32'h3C);
      check("at_0x40", imem_addr, 32'h40);

      // Reset mid-fetch with an Ack pending
      tick();
      rst_n    = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'h5555_AAAA;
      #1;
      check("mrst_pc",  pc,                32'h0);
      check("mrst_req", {31'd0, imem_req}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("mrst_req2",  {31'd0, imem_req},    32'h1);
      check("mrst_addr",  imem_addr,            32'h0);
      check("mrst_valid", {31'd0, instr_valid}, 32'h0);
      tick();
      check("mrst_instr", instr, 32'h5555_AAAA);
      imem_ack = 1'b0;

      // Watchdog: 16 requested FETCH cycles without Ack
      retire(1'b0, 32'h0);
      for (int i = 0; i < 15; i++) tick();
      check("tmo15_valid", {31'd0, instr_valid}, 32'h0);
      check("tmo15_err",   {31'd0, fetch_err},   32'h0);
      tick();
`ifdef FETCH_TIMEOUT_EN
      check("tmo_valid", {31'd0, instr_valid}, 32'h1);
      check("tmo_err",   {31'd0, fetch_err},   32'h1);
      check("tmo_instr", instr,                NOP);
      retire(1'b0, 32'h0);
      check("tmo_clr", {31'd0, fetch_err}, 32'h0);
      check("tmo_pc",  pc,                 32'h8);
`else
      for (int i = 0; i < 10; i++) tick();
      check("notmo_valid", {31'd0, instr_valid}, 32'h0);
      check("notmo_err",   {31'd0, fetch_err},   32'h0);
      check("notmo_req",   {31'd0, imem_req},    32'h1);
      fetch(32'h0000_0077);
      check("notmo_late", instr, 32'h0000_0077);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_instr_fetch_unit

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Rst_n  input  1  asynchronous, active-low reset.
REQ-003 PC_Sel  input  1  next-PC select from control decoder: 0 = PC+4, 1 = PC+4+PC_Immed.
REQ-004 PC_LdEn  input  1  from control decoder; retires the issued instruction and advances PC.
REQ-005 PC_Immed  input  32  branch offset, already sign-extended and shifted left by 2.
REQ-006 Imem_Req  output  1  instruction-memory read request.
REQ-007 Imem_Addr  output  32  word-aligned read address; equals PC.
REQ-008 Imem_Ack  input  1  memory read data valid.
REQ-009 Imem_Rdata  input  32  instruction word returned with Imem_Ack.
REQ-010 Instr  output  32  issued instruction word, fed to the control decoder and decode stage.
REQ-011 Instr_Valid  output  1  Instr holds a fetched instruction awaiting retirement.
REQ-012 PC  output  32  address of the instruction currently fetched or issued.
REQ-013 Fetch_Err  output  1  timeout indication (see Configuration).

Function
REQ-014 FSM states SHALL be FETCH and ISSUE; the first state after reset SHALL be FETCH.
REQ-015 In FETCH: Imem_Req=1, Imem_Addr=PC, Instr_Valid=0. Req and Addr stay stable until the Ack cycle.
REQ-016 FETCH, Imem_Ack=1 -> capture Imem_Rdata into Instr, next state ISSUE. Minimum latency from Req to Instr_Valid = 1 cycle.
REQ-017 In ISSUE: Imem_Req=0, Instr_Valid=1. Instr and PC are held constant.
REQ-018 ISSUE, PC_LdEn=1 -> PC updated per PC_Sel and next state FETCH; PC_LdEn=0 -> remain in ISSUE (stall).
REQ-019 PC_Sel and PC_Immed SHALL be sampled only in the ISSUE cycle in which PC_LdEn=1.
REQ-020 Imem_Ack SHALL be ignored in ISSUE; PC_LdEn and PC_Sel SHALL be ignored in FETCH.
REQ-021 Next-PC arithmetic:
- 32-bit modulo, with wrap-around at 2^32 (0xFFFFFFFC+4 = 0x00000000).
- Bits [1:0] of the result forced to 00.
REQ-022 Back-to-back instructions SHALL take at least 2 cycles each (FETCH + ISSUE); throughput is not pipelined.

Reset
REQ-023 While Rst_n=0, asynchronously:
- PC=0x00000000
- Instr=0x00000000
- Instr_Valid=0, Imem_Req=0, Fetch_Err=0
- state=FETCH
- timeout counter=0
REQ-024 Reset asserted mid-fetch SHALL abandon the request. Any Imem_Ack arriving after reset release refers to the new request at PC=0.
REQ-025 Imem_Req SHALL be asserted in the first clock edge's cycle after Rst_n deasserts.

Configuration
REQ-026 Macro FETCH_TIMEOUT_EN enables the fetch watchdog.
REQ-027 With FETCH_TIMEOUT_EN defined, the watchdog SHALL behave as follows:
- A counter increments each FETCH cycle without Ack and clears on entering FETCH.
- When the counter reaches FETCH_TIMEOUT_CYCLES (16) without Ack, the unit enters ISSUE with Instr=NOP_INSTR and Fetch_Err=1.
- Fetch_Err clears on leaving ISSUE.
REQ-028 Without FETCH_TIMEOUT_EN:
- No counter exists and Fetch_Err is tied to 0.
- FETCH waits for Imem_Ack indefinitely.

Structure
REQ-029 Shared package ifetch_pkg SHALL hold:
- the FSM state type
- RESET_PC (0x00000000)
- PC_INCR (4)
- FETCH_TIMEOUT_CYCLES (16)
- NOP_INSTR (opcode 100000 with register fields and func zero)
REQ-030 Sub-module pc_next SHALL compute PC+4 and PC+4+PC_Immed and apply the alignment mask; it SHALL be purely combinational.

Verification
REQ-031 Reset release with Imem_Ack tied high and Imem_Rdata=0x8000_0001 -> Imem_Req=1 at Addr 0x0 in cycle 1; Instr=0x8000_0001 and Instr_Valid=1 in cycle 2.
REQ-032 ISSUE at PC=0x10, PC_LdEn=1, PC_Sel=1, PC_Immed=0xFFFFFFF0 -> next Imem_Addr=0x4. With PC_Sel=0 instead -> next Imem_Addr=0x14.
REQ-033 Stall: PC_LdEn=0 for 5 ISSUE cycles -> Instr and PC unchanged, Imem_Req=0 throughout; PC advances on the first PC_LdEn=1.
REQ-034 Wrap: PC=0xFFFFFFFC, PC_LdEn=1, PC_Sel=0 -> next Imem_Addr=0x00000000.
REQ-035 Rst_n pulsed low during FETCH at PC=0x40 with Ack pending -> PC=0 immediately, without waiting for a clock edge; the next request is issued at Addr 0x0.
REQ-036 With FETCH_TIMEOUT_EN, Imem_Ack held low for 16 FETCH cycles -> Instr=NOP_INSTR, Fetch_Err=1, Instr_Valid=1. Without the macro, the unit remains in FETCH and Fetch_Err stays 0.
